// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared event/state encodings for the button event controller
package btn_pkg;

  // Event type as seen on evt_type
  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_REPEAT = 2'b11
  } evt_type_t;

  // Press-tracking FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRESS = 2'b01,
    ST_HOLD  = 2'b10
  } fsm_state_t;

  localparam int EVT_TYPE_W = 2;

  // Tick counter must hold the larger threshold without wrapping
  function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
    int m;
    m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - small event queue with sticky overflow flag
module evt_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_tvalid,
  input  logic [WIDTH-1:0] wr_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic [WIDTH-1:0] rd_tdata,
  output logic             drop
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it
  always_comb begin
    full      = (count == CNTW'(DEPTH));
    rd_tvalid = (count != '0);
    do_pop    = rd_tvalid && rd_tready;
    do_push   = wr_tvalid && (!full || do_pop);
    rd_tdata  = rd_tvalid ? mem[rd_ptr] : '0;
  end

  // Storage, pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_tdata;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_tvalid && !do_push) drop <= 1'b1;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - turns button presses into SHORT/LONG/REPEAT events
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [N_BTN-1:0]         btn,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic [1:0]               evt_type,
  output logic                     evt_drop
);

  localparam int IW = $clog2(N_BTN);
  localparam int CW = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

  fsm_state_t          state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       lock_idx;
  logic [N_BTN-1:0]    btn_q;
  logic                armed;
  logic [N_BTN-1:0]    press;
  logic                press_any;
  logic [IW-1:0]       press_idx;
  logic                held;
  logic                push;
  logic [IW-1:0]       push_btn;
  evt_type_t           push_type;
  logic [IW+1:0]       rd_data;

  // History register; armed stays low for one cycle after reset so a button
  // already held at reset release does not look like a fresh press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
    end
  end

  // Rising-edge detect and lowest-index priority pick
  always_comb begin
    press     = armed ? (btn & ~btn_q) : '0;
    press_any = |press;
    press_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) press_idx = IW'(i);
    end
    held = btn[lock_idx];
  end

  // Press tracking FSM; release is tested before the tick so it always wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lock_idx  <= '0;
      push      <= 1'b0;
      push_btn  <= '0;
      push_type <= EVT_NONE;
    end else begin
      push <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press_any) begin
            lock_idx <= press_idx;
            cnt      <= '0;
            state    <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (!held) begin
            push      <= 1'b1;
            push_btn  <= lock_idx;
            push_type <= EVT_SHORT;
            state     <= ST_IDLE;
          end else if (tick) begin
            if (cnt == LONG_LAST) begin
              push      <= 1'b1;
              push_btn  <= lock_idx;
              push_type <= EVT_LONG;
              cnt       <= '0;
              state     <= ST_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!held) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (cnt == REPEAT_LAST) begin
              push      <= 1'b1;
              push_btn  <= lock_idx;
              push_type <= EVT_REPEAT;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  evt_fifo #(
    .DEPTH (2),
    .WIDTH (IW + EVT_TYPE_W)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_tvalid (push),
    .wr_tdata  ({push_btn, push_type}),
    .rd_tvalid (evt_valid),
    .rd_tready (evt_ready),
    .rd_tdata  (rd_data),
    .drop      (evt_drop)
  );

  assign evt_btn  = rd_data[IW+1:2];
  assign evt_type = rd_data[1:0];

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, meaning the number of debounced button inputs (2..8).
REQ-002 The block SHALL have parameter LONG_TICKS, default 1000, meaning the number of ticks held before a LONG event.
REQ-003 The block SHALL have parameter REPEAT_TICKS, default 200, meaning the number of ticks between REPEAT events while held.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port tick, input, 1 bit: single-cycle timebase strobe (nominal 1 ms).
REQ-007 The block SHALL have port btn, input, N_BTN bits: debounced button levels, 1 = pressed.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: an event is available at the queue head.
REQ-009 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts the head event.
REQ-010 The block SHALL have port evt_btn, output, clog2(N_BTN) bits: button index of the head event.
REQ-011 The block SHALL have port evt_type, output, 2 bits: head event type (01 SHORT, 10 LONG, 11 REPEAT).
REQ-012 The block SHALL have port evt_drop, output, 1 bit: sticky flag, set when an event was lost.

Function
REQ-013 The block SHALL detect a press as a 0->1 transition of btn[i], using a registered copy of btn.
REQ-014 The FSM SHALL have states IDLE, PRESS, HOLD, and one locked button index owned at a time.
REQ-015 In IDLE, a press SHALL lock its index, clear the tick counter and enter PRESS in the next cycle.
REQ-016 On simultaneous presses, the lowest index SHALL win; other buttons SHALL be ignored until the FSM returns to IDLE.
REQ-017 In PRESS, each tick SHALL increment the counter; when it reaches LONG_TICKS, the block SHALL push LONG, clear the counter and enter HOLD.
REQ-018 In PRESS, release of the locked button before LONG_TICKS SHALL push SHORT and return to IDLE.
REQ-019 In HOLD, each tick SHALL increment the counter; at REPEAT_TICKS the block SHALL push REPEAT and clear the counter.
REQ-020 In HOLD, release of the locked button SHALL return to IDLE with no event.
REQ-021 Release SHALL take precedence over a tick or threshold occurring in the same cycle.
REQ-022 Events SHALL be pushed into a 2-entry FIFO; a push SHALL be visible on evt_valid one cycle later.
REQ-023 A transfer SHALL occur when evt_valid && evt_ready; evt_btn and evt_type SHALL remain stable while evt_valid && !evt_ready.
REQ-024 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-025 A push to a full FIFO without a simultaneous pop SHALL discard the new event and set evt_drop.
REQ-026 evt_drop SHALL be cleared only by reset.
REQ-027 The counter width SHALL be clog2(max(LONG_TICKS, REPEAT_TICKS)+1), and the counter SHALL never wrap.

Reset
REQ-028 Asserting rst SHALL immediately force the FSM to IDLE, empty the FIFO, and clear the counter, the lock index and the btn history register.
REQ-029 During reset, the outputs SHALL be evt_valid=0, evt_btn=0, evt_type=00 and evt_drop=0.
REQ-030 After reset, a button already held SHALL produce no event until it is released and pressed again.

Structure
REQ-031 The event-type encoding and the FSM state encoding SHALL reside in the shared package btn_pkg.
REQ-032 The FIFO SHALL be a sub-module named evt_fifo (parameterised depth 2, width clog2(N_BTN)+2).

Verification (LONG_TICKS=8, REPEAT_TICKS=4, N_BTN=4, evt_ready=1 unless noted)
REQ-033 Press btn[2] for 3 ticks, then release -> exactly one event, evt_btn=2, evt_type=01.
REQ-034 Hold btn[0] for 20 ticks -> LONG after tick 8, then REPEAT after ticks 12, 16 and 20, and no event on release.
REQ-035 Assert btn[3] and btn[1] in the same cycle -> only button 1 is tracked, and button 3's release produces no event.
REQ-036 Hold evt_ready=0 and generate 3 SHORT presses -> 2 events are held, evt_drop=1, and the first 2 events are delivered in order after evt_ready=1.
REQ-037 Release the button in the same cycle as the 8th tick -> SHORT is emitted, not LONG.
REQ-038 Assert rst in HOLD with one event queued -> evt_valid=0 and the FSM is in IDLE; the still-held button produces nothing until it is re-pressed.
